// File: rtl/logic_op_pipe_if.sv
// Stream interface for logic_op_pipe: operand beat in, result beat out.
// master drives operands and out_ready; slave is the pipe.
interface logic_op_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c;
   logic             c_zero;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, c, c_zero
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, c, c_zero
   );
endinterface

// File: rtl/logic_op_pipe.sv
// Buffered bitwise logic unit: eight ops, DEPTH-entry result FIFO,
// valid/ready on both sides and a wrapping accepted-beat counter.
module logic_op_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   logic_op_pipe_if.slave   bus,
   output logic [CNT_W-1:0] xfer_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   OCC_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]   OCC_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      occ;
   logic             run;
   logic [WIDTH-1:0] res;
   logic             push;
   logic             pop;

   // handshake qualifiers; ready only from registered state
   assign bus.in_ready  = run & (occ < OCC_FULL);
   assign bus.out_valid = (occ != '0);
   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   // head of queue, forced to zero when nothing is queued
   assign bus.c      = bus.out_valid ? mem[rd_ptr] : '0;
   assign bus.c_zero = ~|bus.c;

   // operation decode on the incoming beat
   always_comb begin
      res = '0;
      unique case (bus.op)
         3'd0: res = bus.a & bus.b;
         3'd1: res = bus.a | bus.b;
         3'd2: res = ~(bus.a & bus.b);
         3'd3: res = ~(bus.a | bus.b);
         3'd4: res = bus.a ^ bus.b;
         3'd5: res = ~(bus.a ^ bus.b);
         3'd6: res = ~bus.a;
         3'd7: res = bus.a;
         default: res = '0;
      endcase
   end

   // result storage; contents need no reset, occupancy guards reads
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= res;
   end

   // pointers, occupancy, ready enable and beat counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         run      <= 1'b0;
         xfer_cnt <= '0;
      end else begin
         run <= 1'b1;
         if (push) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            xfer_cnt <= xfer_cnt + CNT_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({push, pop})
            2'b10:   occ <= occ + OCC_ONE;
            2'b01:   occ <= occ - OCC_ONE;
            default: occ <= occ;
         endcase
      end
   end
endmodule
